ccd_stream_gen: RTL and testbench

- Synthetic CCD sensor source that drives the same parallel pixel interface the capture block consumes: 12-bit data, frame-valid and line-valid.
- Produces programmable test patterns with parameterised active and blanking timing.
- Used to exercise the capture path and downstream green-screen logic without a camera attached, on the board or in simulation.
- Sits in place of the sensor pins, muxed ahead of the capture block.

---
 rtl/ccd_pkg.sv | 32 +++
 rtl/ccd_pattern_lut.sv | 23 ++
 rtl/ccd_stream_gen.sv | 176 +++++++++++++++++
 tb/tb_ccd_stream_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared definitions for the synthetic CCD source and the capture path it feeds:
// FSM encoding, pattern codes, data width and default frame timing.
package ccd_pkg;

    localparam int CCD_DATA_W  = 12;
    localparam int CCD_COORD_W = 16;

    // Default timing; DEF_ACTIVE_WIDTH must match the capture block's COLUMN_WIDTH.
    localparam int DEF_ACTIVE_WIDTH  = 1280;
    localparam int DEF_ACTIVE_HEIGHT = 1024;
    localparam int DEF_FV_TO_LV      = 16;
    localparam int DEF_H_BLANK       = 64;
    localparam int DEF_LV_TO_FV      = 16;
    localparam int DEF_V_BLANK       = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_FV_TAIL,
        ST_VBLANK
    } ccd_state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_CONST = 2'd3
    } ccd_pat_t;

endpackage

// File: rtl/ccd_pattern_lut.sv
// Combinational pixel generator: maps the pixel position, the latched pattern
// select and the latched constant to one 12-bit pixel value.
module ccd_pattern_lut
    import ccd_pkg::*;
(
    input  logic [11:0]           i_x,
    input  logic [11:0]           i_y,
    input  ccd_pat_t              i_pattern,
    input  logic [CCD_DATA_W-1:0] i_const,
    output logic [CCD_DATA_W-1:0] o_data
);

    always_comb begin
        o_data = '0;
        unique case (i_pattern)
            PAT_HRAMP: o_data = i_x;
            PAT_VRAMP: o_data = i_y;
            PAT_CHECK: o_data = (i_x[4] ^ i_y[4]) ? '1 : '0;
            PAT_CONST: o_data = i_const;
        endcase
    end

endmodule

// File: rtl/ccd_stream_gen.sv
// Synthetic CCD sensor: emits frame-valid / line-valid / 12-bit pixel data with
// programmable active and blanking timing, standing in for the sensor pins.
module ccd_stream_gen
    import ccd_pkg::*;
#(
    parameter int ACTIVE_WIDTH  = DEF_ACTIVE_WIDTH,
    parameter int ACTIVE_HEIGHT = DEF_ACTIVE_HEIGHT,
    parameter int FV_TO_LV      = DEF_FV_TO_LV,
    parameter int H_BLANK       = DEF_H_BLANK,
    parameter int LV_TO_FV      = DEF_LV_TO_FV,
    parameter int V_BLANK       = DEF_V_BLANK
)
(
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iEnable,
    input  logic [1:0]            iPattern,
    input  logic [CCD_DATA_W-1:0] iConstData,
    output logic [CCD_DATA_W-1:0] oDATA,
    output logic                  oFrameValid,
    output logic                  oLineValid,
    output logic [31:0]           oFrame_Counter,
    output logic                  oFrameDone,
    output logic                  oBusy
);

    localparam logic [CCD_COORD_W-1:0] LAST_X    = CCD_COORD_W'(ACTIVE_WIDTH - 1);
    localparam logic [CCD_COORD_W-1:0] LAST_Y    = CCD_COORD_W'(ACTIVE_HEIGHT - 1);
    localparam logic [CCD_COORD_W-1:0] LEAD_LOAD = CCD_COORD_W'(FV_TO_LV - 1);
    localparam logic [CCD_COORD_W-1:0] HBLK_LOAD = CCD_COORD_W'(H_BLANK - 1);
    localparam logic [CCD_COORD_W-1:0] TAIL_LOAD = CCD_COORD_W'(LV_TO_FV - 1);
    localparam logic [CCD_COORD_W-1:0] VBLK_LOAD = CCD_COORD_W'(V_BLANK - 1);

    ccd_state_t             r_state;
    logic [CCD_COORD_W-1:0] r_x;
    logic [CCD_COORD_W-1:0] r_y;
    logic [CCD_COORD_W-1:0] r_cnt;
    ccd_pat_t               r_pat;
    logic [CCD_DATA_W-1:0]  r_const;
    logic [CCD_DATA_W-1:0]  r_data;
    logic                   r_fv;
    logic                   r_lv;
    logic [31:0]            r_frame_cnt;
    logic                   r_done;
    logic                   r_busy;

    ccd_state_t             w_state_nx;
    logic [CCD_COORD_W-1:0] w_x_nx;
    logic [CCD_COORD_W-1:0] w_y_nx;
    logic [CCD_COORD_W-1:0] w_cnt_nx;
    logic                   w_start;
    logic [CCD_DATA_W-1:0]  w_pix;

    // Outputs are decoded from the next state/position so that the registered
    // oDATA, oLineValid and oFrameValid line up with the state they describe.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_cnt_nx   = r_cnt;
        w_start    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_start = iEnable;
            end
            ST_FV_LEAD: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_LINE;
                    w_x_nx     = '0;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            ST_LINE: begin
                if (r_x == LAST_X) begin
                    w_x_nx = '0;
                    if (r_y < LAST_Y) begin
                        w_y_nx     = r_y + 1'b1;
                        w_cnt_nx   = HBLK_LOAD;
                        w_state_nx = ST_HBLANK;
                    end else begin
                        w_cnt_nx   = TAIL_LOAD;
                        w_state_nx = ST_FV_TAIL;
                    end
                end else begin
                    w_x_nx = r_x + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_LINE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            ST_FV_TAIL: begin
                if (r_cnt == '0) begin
                    w_cnt_nx   = VBLK_LOAD;
                    w_state_nx = ST_VBLANK;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            ST_VBLANK: begin
                if (r_cnt == '0) begin
                    w_start    = iEnable;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (w_start) begin
            w_state_nx = ST_FV_LEAD;
            w_cnt_nx   = LEAD_LOAD;
            w_x_nx     = '0;
            w_y_nx     = '0;
        end
    end

    // Pattern and constant are already latched whenever the next state is LINE.
    ccd_pattern_lut u_lut (
        .i_x       (w_x_nx[11:0]),
        .i_y       (w_y_nx[11:0]),
        .i_pattern (r_pat),
        .i_const   (r_const),
        .o_data    (w_pix)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_pat       <= PAT_HRAMP;
            r_const     <= '0;
            r_data      <= '0;
            r_fv        <= 1'b0;
            r_lv        <= 1'b0;
            r_frame_cnt <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_cnt   <= w_cnt_nx;
            if (w_start) begin
                r_pat       <= ccd_pat_t'(iPattern);
                r_const     <= iConstData;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            r_fv   <= (w_state_nx inside {ST_FV_LEAD, ST_LINE, ST_HBLANK, ST_FV_TAIL});
            r_lv   <= (w_state_nx == ST_LINE);
            r_data <= (w_state_nx == ST_LINE) ? w_pix : '0;
            r_done <= (r_state == ST_FV_TAIL) && (w_state_nx == ST_VBLANK);
            r_busy <= (w_state_nx != ST_IDLE);
        end
    end

    assign oDATA          = r_data;
    assign oFrameValid    = r_fv;
    assign oLineValid     = r_lv;
    assign oFrame_Counter = r_frame_cnt;
    assign oFrameDone     = r_done;
    assign oBusy          = r_busy;

endmodule

// File: tb/tb_ccd_stream_gen.sv
// Randomized bench for ccd_stream_gen: a frame-offset reference model predicts
// every output each cycle; directed phases cover pattern latching and reset.
module tb_ccd_stream_gen;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int FL   = 2;
    localparam int HB   = 3;
    localparam int LT   = 2;
    localparam int VB   = 5;
    localparam int LP   = W + HB;
    localparam int SPAN = H * W + (H - 1) * HB;
    localparam int FVH  = FL + SPAN + LT;
    localparam int PER  = FVH + VB;

    logic        iCLK;
    logic        iRST;
    logic        iEnable;
    logic [1:0]  iPattern;
    logic [11:0] iConstData;
    logic [11:0] oDATA;
    logic        oFrameValid;
    logic        oLineValid;
    logic [31:0] oFrame_Counter;
    logic        oFrameDone;
    logic        oBusy;

    ccd_stream_gen #(
        .ACTIVE_WIDTH  (W),
        .ACTIVE_HEIGHT (H),
        .FV_TO_LV      (FL),
        .H_BLANK       (HB),
        .LV_TO_FV      (LT),
        .V_BLANK       (VB)
    ) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iEnable        (iEnable),
        .iPattern       (iPattern),
        .iConstData     (iConstData),
        .oDATA          (oDATA),
        .oFrameValid    (oFrameValid),
        .oLineValid     (oLineValid),
        .oFrame_Counter (oFrame_Counter),
        .oFrameDone     (oFrameDone),
        .oBusy          (oBusy)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is just a cycle offset m_t from its start edge.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    int unsigned m_frames = 0;
    int          m_pat    = 0;
    logic [11:0] m_const  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_tick();
        if (!iRST) begin
            m_active = 1'b0;
            m_t      = 0;
            m_frames = 0;
        end else if (!m_active || m_t == PER - 1) begin
            if (iEnable) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frames++;
                m_pat    = int'(iPattern);
                m_const  = iConstData;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_all();
        bit          e_fv, e_lv, e_done;
        logic [11:0] e_data;
        int          u, x, y;
        e_fv = 0; e_lv = 0; e_done = 0; e_data = '0;
        if (m_active) begin
            e_fv   = (m_t < FVH);
            e_done = (m_t == FVH);
            u      = m_t - FL;
            if (u >= 0 && u < SPAN && (u % LP) < W) begin
                e_lv = 1;
                x    = u % LP;
                y    = u / LP;
                case (m_pat)
                    0:       e_data = 12'(x);
                    1:       e_data = 12'(y);
                    2:       e_data = (((x / 16) % 2) != ((y / 16) % 2)) ? 12'hFFF : 12'h000;
                    default: e_data = m_const;
                endcase
            end
        end
        check("fv",    32'(oFrameValid),  32'(e_fv));
        check("lv",    32'(oLineValid),   32'(e_lv));
        check("data",  32'(oDATA),        32'(e_data));
        check("done",  32'(oFrameDone),   32'(e_done));
        check("busy",  32'(oBusy),        32'(m_active));
        check("frames", oFrame_Counter,   m_frames);
    endtask

    task automatic step();
        @(posedge iCLK);
        model_tick();
        #1;
        compare_all();
    endtask

    int done_cnt;

    initial begin
        iRST = 1'b0; iEnable = 1'b0; iPattern = 2'd0; iConstData = 12'h000;

        // Held in reset: everything reads 0.
        repeat (3) step();
        iRST = 1'b1;

        // Horizontal ramp, continuous frames.
        iEnable = 1'b1; iPattern = 2'd0; iConstData = 12'(15'($urandom));
        repeat (2 * PER) step();

        // Vertical ramp.
        iPattern = 2'd1;
        repeat (2 * PER) step();

        // Constant pattern; the constant changes mid-frame and must wait a frame.
        iPattern = 2'd3; iConstData = 12'hABC;
        repeat (PER / 2) step();
        iConstData = 12'h123;
        repeat (2 * PER + PER / 2) step();

        // Randomized pattern/const/enable, including idle gaps.
        for (int i = 0; i < 800; i++) begin
            step();
            iPattern   = 2'($urandom_range(0, 3));
            iConstData = 12'($urandom);
            iEnable    = ($urandom_range(0, 3) != 0);
        end

        // Reset asserted during the third line of a frame.
        iEnable = 1'b1; iPattern = 2'd0;
        for (int i = 0; i < 3 * PER && !(m_active && m_t == FL + 2 * LP + 3); i++) step();
        check("reach_line3", 32'(m_active && m_t == FL + 2 * LP + 3), 32'd1);
        iRST = 1'b0;
        #1;
        check("rst_fv",     32'(oFrameValid), 32'd0);
        check("rst_lv",     32'(oLineValid),  32'd0);
        check("rst_data",   32'(oDATA),       32'd0);
        check("rst_busy",   32'(oBusy),       32'd0);
        check("rst_frames", oFrame_Counter,   32'd0);
        repeat (2) step();
        iRST = 1'b1;

        // Restart, then drop enable 10 cycles in: the frame must finish once.
        repeat (10) step();
        iEnable  = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            step();
            done_cnt += int'(oFrameDone);
        end
        check("drop_done_pulses", 32'(done_cnt),    32'd1);
        check("drop_frames",      oFrame_Counter,   32'd1);
        check("drop_busy",        32'(oBusy),       32'd0);
        check("drop_fv",          32'(oFrameValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
